// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: control, ALU status and strobe bundle between a driver and the sequencer
interface exec_sequencer_if #(parameter int RETIRE_W = 16);
  logic run;
  logic step_mode;
  logic load_mode;
  logic [3:0] opcode;
  logic alu_zero;
  logic alu_carry;
  logic ir_load;
  logic pc_inc;
  logic pc_load;
  logic [2:0] alu_op;
  logic rf_write;
  logic zero_flag;
  logic carry_flag;
  logic [2:0] state;
  logic halted;
  logic illegal;
  logic [RETIRE_W-1:0] retired;
  modport master (
    output run, step_mode, load_mode, opcode, alu_zero, alu_carry,
    input ir_load, pc_inc, pc_load, alu_op, rf_write, zero_flag, carry_flag, state, halted, illegal, retired
  );
  modport slave (
    input run, step_mode, load_mode, opcode, alu_zero, alu_carry,
    output ir_load, pc_inc, pc_load, alu_op, rf_write, zero_flag, carry_flag, state, halted, illegal, retired
  );
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer: fetch/decode/exec/writeback control FSM with flags, branch resolution and retire count
module exec_sequencer #(parameter int RETIRE_W = 16) (
  input logic clk,
  input logic reset,
  exec_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, WB = 3'd4, HALT = 3'd5;
  logic [2:0] cur, nxt;
  logic [3:0] op_q;
  logic run_q, zf, cf, ill;
  logic wr_class, cont, done, retire, exec_live;
  logic [RETIRE_W-1:0] retired;
  assign wr_class = op_q inside {[4'd1:4'd7]};
  assign cont = !bus.step_mode && bus.run;
  assign done = (cur == EXEC && !wr_class) || cur == WB;
  assign exec_live = cur == EXEC && !bus.load_mode;
  // entering HALT retires the HLT itself; load_mode abandons whatever is in flight
  assign retire = !bus.load_mode && (done || (cur == DECODE && bus.opcode == 4'hF));
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= IDLE;
    else cur <= nxt;
  always_comb begin
    nxt = IDLE;
    case (cur)
      IDLE: nxt = (bus.run && !run_q) ? FETCH : IDLE;
      FETCH: nxt = DECODE;
      DECODE: nxt = (bus.opcode == 4'hF) ? HALT : EXEC;
      EXEC: nxt = wr_class ? WB : (cont ? FETCH : IDLE);
      WB: nxt = cont ? FETCH : IDLE;
      HALT: nxt = HALT;
      default: nxt = IDLE;
    endcase
    if (bus.load_mode) nxt = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      run_q <= 1'b0;
      op_q <= 4'd0;
      zf <= 1'b0;
      cf <= 1'b0;
      ill <= 1'b0;
      retired <= '0;
    end else begin
      run_q <= bus.run;
      if (cur == DECODE) op_q <= bus.opcode;
      if (exec_live && (wr_class || op_q == 4'hB)) begin
        zf <= bus.alu_zero;
        cf <= bus.alu_carry;
      end
      if (exec_live && op_q inside {[4'hC:4'hE]}) ill <= 1'b1;
      if (retire && retired != '1) retired <= retired + 1'b1;
    end
  always_comb begin
    bus.ir_load = cur == FETCH;
    bus.pc_inc = cur == FETCH;
    bus.rf_write = cur == WB;
    bus.halted = cur == HALT;
    bus.pc_load = cur == EXEC && (op_q == 4'h8 || (op_q == 4'h9 && zf) || (op_q == 4'hA && cf));
    bus.state = cur;
    bus.zero_flag = zf;
    bus.carry_flag = cf;
    bus.illegal = ill;
    bus.retired = retired;
    bus.alu_op = 3'd0;
    if (cur == EXEC || cur == WB)
      case (op_q)
        4'h2, 4'hB: bus.alu_op = 3'd1;
        4'h3: bus.alu_op = 3'd2;
        4'h4: bus.alu_op = 3'd3;
        4'h5: bus.alu_op = 3'd4;
        4'h6: bus.alu_op = 3'd5;
        4'h7: bus.alu_op = 3'd6;
        default: bus.alu_op = 3'd0;
      endcase
  end
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: instruction-level reference model plus directed literal checks and random stimulus
module tb_exec_sequencer;
  localparam int RW = 4;
  localparam int MAXR = (1 << RW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  exec_sequencer_if #(.RETIRE_W(RW)) bus();
  exec_sequencer #(.RETIRE_W(RW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;
  int m_pos = 0, m_halt = 0, m_op = 0, m_z = 0, m_c = 0, m_ill = 0, m_ret = 0, m_runq = 0;
  int prog[$];
  int seq[$];
  int pi, rf_n, pl_n, ir_n;
  int exp_seq[11] = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 3};
  function automatic int writes(input int op);
    return (op >= 1 && op <= 7) ? 1 : 0;
  endfunction
  function automatic int alu_of(input int op);
    case (op)
      2, 11: return 1;
      3: return 2;
      4: return 3;
      5: return 4;
      6: return 5;
      7: return 6;
      default: return 0;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model tracks position within the current instruction; length comes from the opcode class
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pos <= 0; m_halt <= 0; m_op <= 0; m_z <= 0; m_c <= 0; m_ill <= 0; m_ret <= 0; m_runq <= 0;
    end else begin
      m_runq <= int'(bus.run);
      if (bus.load_mode) begin
        m_pos <= 0;
        m_halt <= 0;
      end else if (m_halt == 0) begin
        if (m_pos == 0) begin
          if (bus.run && m_runq == 0) m_pos <= 1;
        end else if (m_pos == 1) m_pos <= 2;
        else if (m_pos == 2) begin
          m_op <= int'(bus.opcode);
          if (bus.opcode == 4'hF) begin
            m_halt <= 1;
            m_pos <= 0;
            m_ret <= (m_ret < MAXR) ? m_ret + 1 : m_ret;
          end else m_pos <= 3;
        end else begin
          if (m_pos == 3 && (writes(m_op) == 1 || m_op == 11)) begin
            m_z <= int'(bus.alu_zero);
            m_c <= int'(bus.alu_carry);
          end
          if (m_pos == 3 && m_op >= 12 && m_op <= 14) m_ill <= 1;
          if (m_pos == 3 + writes(m_op)) begin
            m_ret <= (m_ret < MAXR) ? m_ret + 1 : m_ret;
            m_pos <= (!bus.step_mode && bus.run) ? 1 : 0;
          end else m_pos <= m_pos + 1;
        end
      end
    end
  end
  always @(negedge clk) if (chk_on) begin
    chk("state", 32'(bus.state), 32'(m_halt != 0 ? 5 : m_pos));
    chk("ir_load", 32'(bus.ir_load), 32'(m_pos == 1));
    chk("pc_inc", 32'(bus.pc_inc), 32'(m_pos == 1));
    chk("rf_write", 32'(bus.rf_write), 32'(m_pos == 4));
    chk("pc_load", 32'(bus.pc_load),
        32'(m_pos == 3 && (m_op == 8 || (m_op == 9 && m_z == 1) || (m_op == 10 && m_c == 1))));
    chk("zero_flag", 32'(bus.zero_flag), 32'(m_z));
    chk("carry_flag", 32'(bus.carry_flag), 32'(m_c));
    chk("halted", 32'(bus.halted), 32'(m_halt));
    chk("illegal", 32'(bus.illegal), 32'(m_ill));
    chk("retired", 32'(bus.retired), 32'(m_ret));
    if (m_pos >= 3) chk("alu_op", 32'(bus.alu_op), 32'(alu_of(m_op)));
  end
  task automatic do_reset();
    @(negedge clk);
    bus.run = 0; bus.load_mode = 0; bus.step_mode = 0; bus.opcode = 0;
    bus.alu_zero = 0; bus.alu_carry = 0;
    #2 reset = 1;
    @(negedge clk);
    reset = 0;
    chk_on = 1;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_retired", 32'(bus.retired), 0);
    chk("rst_illegal", 32'(bus.illegal), 0);
    chk("rst_flags", 32'({bus.zero_flag, bus.carry_flag}), 0);
  endtask
  task automatic run_prog(input int hold, input int total);
    pi = 0; rf_n = 0; pl_n = 0; ir_n = 0;
    seq.delete();
    @(negedge clk);
    bus.run = 1;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      seq.push_back(int'(bus.state));
      rf_n += int'(bus.rf_write);
      pl_n += int'(bus.pc_load);
      ir_n += int'(bus.ir_load);
      if (bus.ir_load) begin
        bus.opcode = (pi < prog.size()) ? 4'(prog[pi]) : 4'd0;
        pi++;
      end
      if (c == hold) bus.run = 0;
    end
  endtask
  initial begin
    bus.run = 0; bus.load_mode = 0; bus.step_mode = 0; bus.opcode = 0;
    bus.alu_zero = 0; bus.alu_carry = 0;
    do_reset();
    // reset while the second ADD is in writeback
    prog = '{1, 1}; pi = 0; rf_n = 0;
    @(negedge clk);
    bus.run = 1;
    for (int c = 0; c < 12 && rf_n < 2; c++) begin
      @(negedge clk);
      if (bus.ir_load) begin
        bus.opcode = 4'(prog[pi]);
        pi++;
      end
      rf_n += int'(bus.rf_write);
    end
    chk("wb_reached", 32'(rf_n), 2);
    chk("ret_before_reset", 32'(bus.retired), 1);
    #1 reset = 1;
    #1;
    chk("async_rf_write", 32'(bus.rf_write), 0);
    chk("async_state", 32'(bus.state), 0);
    chk("async_retired", 32'(bus.retired), 0);
    @(negedge clk);
    reset = 0;
    bus.run = 0;
    // ADD, SUB, JMP back to back
    do_reset();
    prog = '{1, 2, 8};
    run_prog(11, 12);
    for (int i = 0; i < 11; i++) chk("seq_add_sub_jmp", 32'(seq[i]), 32'(exp_seq[i]));
    chk("seq_rf_count", 32'(rf_n), 2);
    chk("seq_retired", 32'(bus.retired), 3);
    chk("seq_end_idle", 32'(seq[11]), 0);
    // SUB then JZ, zero set and clear
    do_reset();
    prog = '{2, 9};
    bus.alu_zero = 1;
    run_prog(6, 8);
    chk("jz_taken", 32'(pl_n), 1);
    do_reset();
    prog = '{2, 9};
    bus.alu_zero = 0;
    run_prog(6, 8);
    chk("jz_not_taken", 32'(pl_n), 0);
    // single step MOV with run held high
    do_reset();
    prog = '{7, 7};
    bus.step_mode = 1;
    run_prog(10, 10);
    chk("step_fetches", 32'(ir_n), 1);
    chk("step_active", 32'(seq[3]), 4);
    chk("step_idle", 32'(seq[4]), 0);
    chk("step_retired", 32'(bus.retired), 1);
    bus.step_mode = 0;
    // illegal opcode then HLT
    do_reset();
    prog = '{13, 15};
    run_prog(20, 8);
    chk("ill_sticky", 32'(bus.illegal), 1);
    chk("ill_no_write", 32'(rf_n), 0);
    chk("hlt_halted", 32'(bus.halted), 1);
    chk("hlt_retired", 32'(bus.retired), 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.run = ~bus.run;
    end
    @(negedge clk);
    chk("hlt_persists", 32'(bus.state), 5);
    bus.load_mode = 1;
    @(negedge clk);
    bus.load_mode = 0;
    chk("hlt_exit", 32'(bus.state), 0);
    chk("hlt_exit_ill", 32'(bus.illegal), 1);
    bus.run = 0;
    // NOP stream saturates the counter
    do_reset();
    prog.delete();
    run_prog(60, 62);
    chk("sat_retired", 32'(bus.retired), MAXR);
    // randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (reset) reset = 0;
      if ($urandom_range(0, 5) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 49) == 0) bus.step_mode = ~bus.step_mode;
      bus.load_mode = ($urandom_range(0, 39) == 0);
      bus.opcode = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      bus.alu_zero = 1'($urandom_range(0, 1));
      bus.alu_carry = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 599) == 0) #2 reset = 1;
    end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
